nabp_processing_scheduler: RTL
==============================

NABP_PROCESSING_SCHEDULER -- requirements
Module: nabp_processing_scheduler

Interface
REQ-001 Parameter: kLineSize, default 256, projection line length in samples; even, at least 2.
REQ-002 Parameter: kAngleLength and kSLength, from the shared defines, angle and s-value widths.
REQ-003 clk  in  1  sole clock; all logic on rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 start  in  1  one-cycle pulse that begins a projection run; ignored unless IDLE.
REQ-006 pr_next_angle  out  1  angle request to the swap control; level signal.
REQ-007 pr_next_angle_ack  in  1  swap control acknowledge; four-phase with pr_next_angle.
REQ-008 pr_angle  in  kAngleLength  angle of the buffer just swapped in; valid while ack=1.
REQ-009 hs_has_next_angle  in  1  host has further angles; 0 marks the final angle.
REQ-010 pr0_s_val, pr1_s_val  out  kSLength  read addresses to the two filtered-RAM swappables.
REQ-011 pe_ready  in  1  processing elements accept data this cycle.
REQ-012 pe_valid  out  1  pr0_val and pr1_val (RAM outputs) are valid for the PEs.
REQ-013 pe_angle  out  kAngleLength  angle for the current sweep.
REQ-014 pe_first, pe_last  out  1  first and last sample pair of a sweep, qualified by pe_valid.
REQ-015 busy  out  1  high in any state except IDLE.
REQ-016 done  out  1  one-cycle pulse when the final angle's sweep completes.

Function
REQ-017 FSM states: IDLE, REQ, SWEEP, DRAIN, WAIT_ACK_LOW, DONE.
REQ-018 IDLE -> REQ on start; REQ drives pr_next_angle=1 until pr_next_angle_ack is sampled 1.
REQ-019 On the ack edge: latch pr_angle into pe_angle, latch last=!hs_has_next_angle, clear the pair counter k, drop pr_next_angle, enter SWEEP.
REQ-020 SWEEP: pr0_s_val=2k and pr1_s_val=2k+1, combinational from k; k increments when pe_ready=1 and holds when pe_ready=0.
REQ-021 Read latency is 1 cycle: pe_valid, pe_first and pe_last are the registered issue-cycle flags, so pe_valid is high the cycle after an address pair issues with pe_ready=1.
REQ-022 During a stall (pe_ready=0), addresses and pe_valid hold, so the same data is re-presented.
REQ-023 The address pair with k=kLineSize/2-1 is the last; after it issues, go to DRAIN for one cycle so the final pe_valid is delivered.
REQ-024 DRAIN -> DONE if last=1; otherwise -> WAIT_ACK_LOW.
REQ-025 WAIT_ACK_LOW waits for pr_next_angle_ack=0, then -> REQ; a new request never rises while ack is high.
REQ-026 DONE asserts done for one cycle, then -> IDLE.
REQ-027 Outside SWEEP, pr0_s_val and pr1_s_val are 0 and no new pe_valid is generated.
REQ-028 The counter is kSLength wide; 2k+1 never exceeds kLineSize-1, so no wrap occurs.
REQ-029 start asserted while busy=1 is ignored and has no side effects.
REQ-030 An ack that is already high on entry to REQ is consumed only after WAIT_ACK_LOW; from IDLE, ack must be 0 at start.

Reset
REQ-031 Reset at any cycle, including mid-sweep or mid-handshake, takes effect at the same edge: state IDLE; pr_next_angle, pe_valid, pe_first, pe_last, busy and done 0; k, pe_angle and last 0.
REQ-032 After reset, start is honoured on the first cycle that reset is low.

Structure
REQ-033 kLineSize, kSLength and kAngleLength come from the shared defines; FSM state encodings are local.
REQ-034 One sub-module is natural: nabp_sweep_counter, holding the pair counter, stall hold, and first/last flag generation with its 1-cycle pipeline.

Verification
REQ-035 kLineSize=8, pe_ready=1, one angle (hs_has_next_angle=0), ack 2 cycles after request, pr_angle=5 -> pairs (0,1),(2,3),(4,5),(6,7) on 4 consecutive cycles; pe_valid for 4 cycles, delayed 1; pe_first on pair 0; pe_last on pair 3; pe_angle=5; done exactly once.
REQ-036 Three angles 1, 2, 3, with ack held high 3 cycles each -> pr_next_angle does not re-rise until ack is low; three sweeps with pe_angle 1, 2, 3; done only after the third.
REQ-037 pe_ready=0 for 3 cycles at k=2 -> addresses hold (4,5); pe_valid stays high; no pair is skipped or duplicated downstream; total of 4 accepted pairs.
REQ-038 Reset asserted at k=2 mid-sweep -> all outputs at reset values the next cycle; a new start yields a clean sweep from (0,1).
REQ-039 start pulsed during SWEEP -> no effect; exactly one request per angle.
REQ-040 Reset asserted while pr_next_angle=1 -> request drops the next cycle; an ack arriving afterward in IDLE is ignored.

Source files
------------

// File: rtl/nabp_processing_scheduler_pkg.sv
// rtl/nabp_processing_scheduler_pkg.sv - shared widths, PE flag bundle and address helper for the NABP scheduler
package nabp_processing_scheduler_pkg;

  localparam int kLineSizeDefault = 256;
  localparam int kSLength         = 9;
  localparam int kAngleLength     = 9;

  typedef struct packed {
    logic valid;
    logic first;
    logic last;
  } pe_flags_t;

  // Pair k covers samples 2k and 2k+1; odd selects the second swappable's address.
  function automatic logic [kSLength-1:0] pair_addr(input logic [kSLength-1:0] k, input logic odd);
    return (k << 1) | {{(kSLength-1){1'b0}}, odd};
  endfunction

endpackage

// File: rtl/nabp_processing_scheduler_if.sv
// rtl/nabp_processing_scheduler_if.sv - control, swap-handshake and PE-side signals of the scheduler
interface nabp_processing_scheduler_if;
  import nabp_processing_scheduler_pkg::*;

  logic                    start;
  logic                    pr_next_angle;
  logic                    pr_next_angle_ack;
  logic [kAngleLength-1:0] pr_angle;
  logic                    hs_has_next_angle;
  logic [kSLength-1:0]     pr0_s_val;
  logic [kSLength-1:0]     pr1_s_val;
  logic                    pe_ready;
  logic                    pe_valid;
  logic [kAngleLength-1:0] pe_angle;
  logic                    pe_first;
  logic                    pe_last;
  logic                    busy;
  logic                    done;

  modport slave (
    input  start, pr_next_angle_ack, pr_angle, hs_has_next_angle, pe_ready,
    output pr_next_angle, pr0_s_val, pr1_s_val, pe_valid, pe_angle, pe_first, pe_last, busy, done
  );

  modport master (
    output start, pr_next_angle_ack, pr_angle, hs_has_next_angle, pe_ready,
    input  pr_next_angle, pr0_s_val, pr1_s_val, pe_valid, pe_angle, pe_first, pe_last, busy, done
  );

endinterface

// File: rtl/nabp_sweep_counter.sv
// rtl/nabp_sweep_counter.sv - pair counter with stall hold and 1-cycle first/last/valid pipeline
module nabp_sweep_counter
  import nabp_processing_scheduler_pkg::*;
#(
  parameter int kLineSize = kLineSizeDefault
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                i_clear,
  input  logic                i_sweep,
  input  logic                i_pe_ready,
  output logic [kSLength-1:0] o_s0,
  output logic [kSLength-1:0] o_s1,
  output logic                o_last_pair,
  output pe_flags_t           o_flags
);

  localparam int                  kLastKInt = kLineSize / 2 - 1;
  localparam logic [kSLength-1:0] kLastK    = kLastKInt[kSLength-1:0];

  logic [kSLength-1:0] r_k;
  pe_flags_t           r_flags;
  logic                w_issue;

  assign w_issue     = i_sweep && i_pe_ready;
  assign o_last_pair = (r_k == kLastK);
  assign o_s0        = i_sweep ? pair_addr(r_k, 1'b0) : '0;
  assign o_s1        = i_sweep ? pair_addr(r_k, 1'b1) : '0;
  assign o_flags     = r_flags;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_k <= '0;
    end else if (i_clear || (w_issue && o_last_pair)) begin
      r_k <= '0;
    end else if (w_issue) begin
      r_k <= r_k + 1'b1;
    end
  end

  // The flag stage only advances when the PEs accept, so a stall re-presents the same flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_flags <= '0;
    end else if (i_pe_ready) begin
      r_flags.valid <= i_sweep;
      r_flags.first <= i_sweep && (r_k == '0);
      r_flags.last  <= i_sweep && o_last_pair;
    end
  end

endmodule

// File: rtl/nabp_processing_scheduler.sv
// rtl/nabp_processing_scheduler.sv - per-angle request/sweep/drain sequencer feeding the processing elements
module nabp_processing_scheduler
  import nabp_processing_scheduler_pkg::*;
#(
  parameter int kLineSize = kLineSizeDefault
) (
  input logic                         clk,
  input logic                         reset,
  nabp_processing_scheduler_if.slave  bus
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_SWEEP,
    ST_DRAIN,
    ST_WAIT_ACK_LOW,
    ST_DONE
  } state_t;

  state_t                  r_state;
  state_t                  w_next_state;
  logic [kAngleLength-1:0] r_pe_angle;
  logic                    r_last;
  logic                    w_ack_edge;
  logic                    w_sweep;
  logic                    w_last_pair;
  logic [kSLength-1:0]     w_s0;
  logic [kSLength-1:0]     w_s1;
  pe_flags_t               w_flags;

  assign w_ack_edge = (r_state == ST_REQ) && bus.pr_next_angle_ack;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE:         if (bus.start) w_next_state = ST_REQ;
      ST_REQ:          if (bus.pr_next_angle_ack) w_next_state = ST_SWEEP;
      ST_SWEEP:        if (bus.pe_ready && w_last_pair) w_next_state = ST_DRAIN;
      ST_DRAIN:        w_next_state = r_last ? ST_DONE : ST_WAIT_ACK_LOW;
      ST_WAIT_ACK_LOW: if (!bus.pr_next_angle_ack) w_next_state = ST_REQ;
      ST_DONE:         w_next_state = ST_IDLE;
      default:         w_next_state = ST_IDLE;
    endcase
  end

  always_comb begin
    bus.pr_next_angle = (r_state == ST_REQ);
    bus.busy          = (r_state != ST_IDLE);
    bus.done          = (r_state == ST_DONE);
    w_sweep           = (r_state == ST_SWEEP);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pe_angle <= '0;
      r_last     <= 1'b0;
    end else if (w_ack_edge) begin
      r_pe_angle <= bus.pr_angle;
      r_last     <= !bus.hs_has_next_angle;
    end
  end

  nabp_sweep_counter #(
    .kLineSize (kLineSize)
  ) u_sweep_counter (
    .clk         (clk),
    .reset       (reset),
    .i_clear     (w_ack_edge),
    .i_sweep     (w_sweep),
    .i_pe_ready  (bus.pe_ready),
    .o_s0        (w_s0),
    .o_s1        (w_s1),
    .o_last_pair (w_last_pair),
    .o_flags     (w_flags)
  );

  assign bus.pr0_s_val = w_s0;
  assign bus.pr1_s_val = w_s1;
  assign bus.pe_valid  = w_flags.valid;
  assign bus.pe_first  = w_flags.first;
  assign bus.pe_last   = w_flags.last;
  assign bus.pe_angle  = r_pe_angle;

endmodule
